// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampling, 3-sample majority) feeding a first-word-fall-through FIFO.
// Latency: a frame is pushed at tick 9 of its final stop bit and appears on rd_* one clk later.
// Backpressure: none on the line side; when the FIFO is full, a new frame is dropped and overrun is set.
//
// Ports:
//   clk, rst            - single clock, asynchronous active-high reset
//   rx                  - serial line, asynchronous to clk, idle high
//   cfg_div             - clk cycles per oversample tick (0 and 1 act as 2), latched at the start edge
//   cfg_parity          - 00 none, 01 even, 10 odd, 11 none; latched at the start edge
//   cfg_stop2           - two stop bits when 1; latched at the start edge
//   rd_en / rd_valid    - pop the head entry / FIFO not empty
//   rd_data, rd_parity_err, rd_frame_err, rd_break - head entry contents (zero while empty)
//   fifo_count          - occupied entries
//   overrun, overrun_clr - sticky dropped-frame flag and its clear (set wins)
//   rx_busy             - receiver is anywhere but IDLE
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int RESET_DIV  = 54
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic [DIV_WIDTH-1:0]          cfg_div,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_parity_err,
  output logic                          rd_frame_err,
  output logic                          rd_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic                          rx_busy
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int BCW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } state_t;

  typedef struct packed {
    logic                  brk;
    logic                  ferr;
    logic                  perr;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  // ---------------------------------------------------------------------
  // Line synchroniser and start-edge detect
  // ---------------------------------------------------------------------
  logic rx_s1, rx_s2, rx_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  state_t state, state_nxt;

  logic start_det;
  assign start_det = (state == S_IDLE) && rx_prev && !rx_s2;

  // ---------------------------------------------------------------------
  // Frame datapath registers
  // ---------------------------------------------------------------------
  logic [DIV_WIDTH-1:0]  div_l;
  logic [DIV_WIDTH-1:0]  div_cnt;
  logic [3:0]            tick_idx;
  logic                  par_en_l;
  logic                  par_odd_l;
  logic                  stop2_l;
  logic                  samp7;
  logic                  samp8;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BCW-1:0]        bit_cnt;
  logic                  par_acc;
  logic                  perr_l;
  logic                  ferr_acc;
  logic                  zero_acc;
  logic                  stop_idx;

  logic tick, mid, bit_end, maj, last_stop, brk_now, ferr_now, push;

  assign tick      = (state != S_IDLE) && (div_cnt == div_l - DIV_WIDTH'(1));
  assign mid       = tick && (tick_idx == 4'd9);
  assign bit_end   = tick && (tick_idx == 4'd15);
  // The third sample is the live line value at tick 9.
  assign maj       = (samp7 & samp8) | (samp7 & rx_s2) | (samp8 & rx_s2);
  assign last_stop = !stop2_l || stop_idx;
  // In two-stop mode the first stop bit is already folded into zero_acc by
  // the time the second one is resolved.
  assign brk_now   = zero_acc & (stop_idx | ~maj);
  assign ferr_now  = ferr_acc | ~maj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_l     <= DIV_WIDTH'(RESET_DIV);
      div_cnt   <= '0;
      tick_idx  <= '0;
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      stop2_l   <= 1'b0;
      samp7     <= 1'b1;
      samp8     <= 1'b1;
      shreg     <= '0;
      bit_cnt   <= '0;
      par_acc   <= 1'b0;
      perr_l    <= 1'b0;
      ferr_acc  <= 1'b0;
      zero_acc  <= 1'b1;
      stop_idx  <= 1'b0;
    end else if (start_det) begin
      div_l     <= (cfg_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_div;
      par_en_l  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_odd_l <= (cfg_parity == 2'b10);
      stop2_l   <= cfg_stop2;
      div_cnt   <= '0;
      tick_idx  <= '0;
      bit_cnt   <= '0;
      par_acc   <= 1'b0;
      perr_l    <= 1'b0;
      ferr_acc  <= 1'b0;
      zero_acc  <= 1'b1;
      stop_idx  <= 1'b0;
    end else if (state != S_IDLE) begin
      if (tick) begin
        div_cnt  <= '0;
        tick_idx <= tick_idx + 4'd1;
      end else begin
        div_cnt  <= div_cnt + DIV_WIDTH'(1);
      end

      if (tick && tick_idx == 4'd7) samp7 <= rx_s2;
      if (tick && tick_idx == 4'd8) samp8 <= rx_s2;

      if (mid) begin
        case (state)
          S_DATA: begin
            shreg    <= {maj, shreg[DATA_WIDTH-1:1]};
            par_acc  <= par_acc ^ maj;
            zero_acc <= zero_acc & ~maj;
          end
          S_PARITY: begin
            perr_l   <= par_odd_l ? ~(par_acc ^ maj) : (par_acc ^ maj);
            zero_acc <= zero_acc & ~maj;
          end
          S_STOP: begin
            if (!stop_idx) begin
              ferr_acc <= ferr_acc | ~maj;
              zero_acc <= zero_acc & ~maj;
            end
          end
          default: ;
        endcase
      end

      if (bit_end) begin
        if (state == S_DATA) bit_cnt  <= bit_cnt + BCW'(1);
        if (state == S_STOP) stop_idx <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start_det) state_nxt = S_START;
      S_START: begin
        if (mid && maj)   state_nxt = S_IDLE;
        else if (bit_end) state_nxt = S_DATA;
      end
      S_DATA:
        if (bit_end && bit_cnt == BCW'(DATA_WIDTH - 1))
          state_nxt = par_en_l ? S_PARITY : S_STOP;
      S_PARITY:   if (bit_end) state_nxt = S_STOP;
      // Leave at the middle of the final stop bit so a following start bit
      // is seen even when frames are sent back to back.
      S_STOP:     if (mid && last_stop) state_nxt = brk_now ? S_BRK_WAIT : S_IDLE;
      S_BRK_WAIT: if (rx_s2) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state != S_IDLE);
    push    = (state == S_STOP) && mid && last_stop;
  end

  // ---------------------------------------------------------------------
  // Receive FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------
  ent_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, do_wr, drop;
  ent_t          wr_ent, head;

  assign full   = (count == CW'(FIFO_DEPTH));
  assign pop    = rd_en && (count != '0);
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign do_wr  = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign wr_ent = '{brk: brk_now, ferr: ferr_now, perr: perr_l, data: shreg};

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({do_wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  assign head          = mem[rd_ptr];
  assign rd_valid      = (count != '0);
  assign fifo_count    = count;
  assign rd_data       = rd_valid ? head.data : '0;
  assign rd_parity_err = rd_valid & head.perr;
  assign rd_frame_err  = rd_valid & head.ferr;
  assign rd_break      = rd_valid & head.brk;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: serial frames are generated on rx, and the expected
// FIFO contents are kept as a queue of entries derived from the frame bits.
// The queue is compared against the DUT every cycle, alongside literal expectations.
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic       brk;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        rd_en;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_parity_err;
  logic        rd_frame_err;
  logic        rd_break;
  logic [2:0]  fifo_count;
  logic        overrun;
  logic        overrun_clr;
  logic        rx_busy;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_WIDTH(8),
    .DIV_WIDTH (16),
    .FIFO_DEPTH(DEPTH),
    .RESET_DIV (54)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .cfg_div      (cfg_div),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .rd_en        (rd_en),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_parity_err(rd_parity_err),
    .rd_frame_err (rd_frame_err),
    .rd_break     (rd_break),
    .fifo_count   (fifo_count),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .rx_busy      (rx_busy)
  );

  // Expected FIFO contents, oldest first. A frame's entry is queued when the
  // frame starts; 'inflight' marks that it may not have reached the DUT yet.
  ent_t mq[$];
  int   inflight = 0;
  bit   exp_ovr  = 1'b0;
  bit   chk_en   = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  ent_t cmp_got;
  int   cmp_sz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_sz  = mq.size();
      cmp_got = {rd_break, rd_frame_err, rd_parity_err, rd_data};
      checks++;
      if (rd_valid) begin
        if (cmp_sz == 0) begin
          failures++;
          $display("FAIL cmp_head: got %0h expected empty fifo", cmp_got);
        end else if (cmp_got !== mq[0]) begin
          failures++;
          $display("FAIL cmp_head: got %0h expected %0h", cmp_got, mq[0]);
        end
      end
      checks++;
      if (int'(fifo_count) < cmp_sz - inflight || int'(fifo_count) > cmp_sz) begin
        failures++;
        $display("FAIL cmp_count: got %0d expected %0d..%0d", fifo_count, cmp_sz - inflight, cmp_sz);
      end
      checks++;
      if (rd_valid !== (fifo_count != 3'd0)) begin
        failures++;
        $display("FAIL cmp_valid: got %0b expected %0b", rd_valid, fifo_count != 3'd0);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame using the current cfg_* values and queue its expected entry.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1,
                            input logic s2, input int idle);
    int   eff, bp, ones;
    logic pen;
    ent_t e;
    eff    = (cfg_div < 16'd2) ? 2 : int'(cfg_div);
    bp     = 16 * eff;
    pen    = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    ones   = $countones(d) + int'(pbit);
    e.data = d;
    e.perr = pen && ((cfg_parity == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0));
    e.ferr = !s1 || (cfg_stop2 && !s2);
    e.brk  = (d == 8'd0) && (!pen || !pbit) && !s1;
    if (mq.size() >= DEPTH) exp_ovr = 1'b1;
    else begin
      mq.push_back(e);
      inflight = 1;
    end
    rx = 1'b0; hold(bp);
    for (int i = 0; i < 8; i++) begin
      rx = d[i]; hold(bp);
    end
    if (pen) begin
      rx = pbit; hold(bp);
    end
    rx = s1; hold(bp);
    if (cfg_stop2) begin
      rx = s2; hold(bp);
    end
    inflight = 0;
    rx = 1'b1;
    hold(idle);
  endtask

  task automatic pop1();
    @(negedge clk) rd_en = 1'b1;
    @(posedge clk);
    if (mq.size() > 0) mq.delete(0);
    @(negedge clk) rd_en = 1'b0;
  endtask

  task automatic chk_head(input string name, input ent_t exp);
    chk({name, "_vld"}, 32'(rd_valid), 32'd1);
    chk(name, 32'({rd_break, rd_frame_err, rd_parity_err, rd_data}), 32'(exp));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    rx          = 1'b1;
    cfg_div     = 16'd4;
    cfg_parity  = 2'b00;
    cfg_stop2   = 1'b0;
    rd_en       = 1'b0;
    overrun_clr = 1'b0;
    hold(3);
    rst = 1'b0;
    hold(2);

    // Reset state
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data",  32'(rd_data), 0);
    chk("rst_flags", 32'({rd_break, rd_frame_err, rd_parity_err}), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovr",   32'(overrun), 0);
    chk("rst_busy",  32'(rx_busy), 0);
    chk_en = 1'b1;

    // 8N1 back-to-back frames
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 10);
    chk("b2b_count", 32'(fifo_count), 2);
    chk_head("b2b_first", '{brk: 1'b0, ferr: 1'b0, perr: 1'b0, data: 8'hA5});
    pop1();
    chk_head("b2b_second", '{brk: 1'b0, ferr: 1'b0, perr: 1'b0, data: 8'h3C});
    pop1();
    chk("b2b_empty", 32'(rd_valid), 0);

    // Parity: 0x07 has three ones
    cfg_parity = 2'b01;
    send_frame(8'h07, 1'b0, 1'b1, 1'b1, 10);
    chk_head("even_bad", '{brk: 1'b0, ferr: 1'b0, perr: 1'b1, data: 8'h07});
    pop1();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 10);
    chk_head("even_good", '{brk: 1'b0, ferr: 1'b0, perr: 1'b0, data: 8'h07});
    pop1();
    cfg_parity = 2'b10;
    send_frame(8'h07, 1'b0, 1'b1, 1'b1, 10);
    chk_head("odd_good", '{brk: 1'b0, ferr: 1'b0, perr: 1'b0, data: 8'h07});
    pop1();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 10);
    chk_head("odd_bad", '{brk: 1'b0, ferr: 1'b0, perr: 1'b1, data: 8'h07});
    pop1();

    // 8N2 with a low second stop bit, then a long break
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b1;
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 10);
    chk_head("stop2_low", '{brk: 1'b0, ferr: 1'b1, perr: 1'b0, data: 8'h55});
    pop1();
    mq.push_back('{brk: 1'b1, ferr: 1'b1, perr: 1'b0, data: 8'h00});
    inflight = 1;
    rx = 1'b0;
    hold(3 * 12 * 64);
    inflight = 0;
    chk("brk_busy", 32'(rx_busy), 1);
    chk("brk_count", 32'(fifo_count), 1);
    chk_head("brk_entry", '{brk: 1'b1, ferr: 1'b1, perr: 1'b0, data: 8'h00});
    rx = 1'b1;
    hold(10);
    chk("brk_idle", 32'(rx_busy), 0);
    chk("brk_count2", 32'(fifo_count), 1);
    pop1();
    cfg_stop2 = 1'b0;

    // Short low glitch is rejected
    rx = 1'b0;
    hold(15);
    chk("glitch_busy", 32'(rx_busy), 1);
    hold(5);
    rx = 1'b1;
    hold(100);
    chk("glitch_idle", 32'(rx_busy), 0);
    chk("glitch_count", 32'(fifo_count), 0);

    // Overrun with a 4-deep FIFO
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, 0);
    send_frame(8'h33, 1'b0, 1'b1, 1'b1, 0);
    send_frame(8'h44, 1'b0, 1'b1, 1'b1, 0);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 10);
    chk("ovr_count", 32'(fifo_count), 4);
    chk("ovr_flag", 32'(overrun), 32'(exp_ovr));
    chk("ovr_flag_lit", 32'(overrun), 1);
    chk_head("ovr_e1", '{brk: 1'b0, ferr: 1'b0, perr: 1'b0, data: 8'h11});
    pop1();
    chk_head("ovr_e2", '{brk: 1'b0, ferr: 1'b0, perr: 1'b0, data: 8'h22});
    pop1();
    chk_head("ovr_e3", '{brk: 1'b0, ferr: 1'b0, perr: 1'b0, data: 8'h33});
    pop1();
    chk_head("ovr_e4", '{brk: 1'b0, ferr: 1'b0, perr: 1'b0, data: 8'h44});
    pop1();
    chk("ovr_empty", 32'(rd_valid), 0);
    chk("ovr_sticky", 32'(overrun), 1);
    @(negedge clk) overrun_clr = 1'b1;
    @(negedge clk) overrun_clr = 1'b0;
    exp_ovr = 1'b0;
    chk("ovr_clr", 32'(overrun), 0);

    // Reset in the middle of a data bit with two entries stored
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, 0);
    send_frame(8'h42, 1'b0, 1'b1, 1'b1, 10);
    rx = 1'b0; hold(64);
    rx = 1'b1; hold(64);
    rx = 1'b0; hold(32);
    chk("prerst_count", 32'(fifo_count), 2);
    chk("prerst_busy", 32'(rx_busy), 1);
    chk_en = 1'b0;
    rst = 1'b1;
    mq.delete();
    hold(2);
    chk("mrst_valid", 32'(rd_valid), 0);
    chk("mrst_data", 32'({rd_break, rd_frame_err, rd_parity_err, rd_data}), 0);
    chk("mrst_count", 32'(fifo_count), 0);
    chk("mrst_busy", 32'(rx_busy), 0);
    rx = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(5);
    chk_en = 1'b1;
    send_frame(8'h96, 1'b0, 1'b1, 1'b1, 10);
    chk_head("postrst", '{brk: 1'b0, ferr: 1'b0, perr: 1'b0, data: 8'h96});
    pop1();

    // Randomised frames, configurations and error injection
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic       pb, s1, s2;
      int         idle;
      cfg_div    = 16'($urandom_range(0, 5));
      cfg_parity = 2'($urandom_range(0, 3));
      cfg_stop2  = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      pb = (cfg_parity == 2'b10) ? ~(^d) : (^d);
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      s1 = ($urandom_range(0, 4) != 0);
      s2 = ($urandom_range(0, 4) != 0);
      idle = (s1 && (s2 || !cfg_stop2)) ? $urandom_range(0, 8) : $urandom_range(4, 12);
      if (mq.size() >= DEPTH) pop1();
      send_frame(d, pb, s1, s2, idle);
      if (mq.size() > 0 && $urandom_range(0, 2) == 0) pop1();
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (mq.size() > 0) pop1();
    end
    hold(2);
    chk("final_count", 32'(fifo_count), 0);
    chk("final_ovr", 32'(overrun), 32'(exp_ovr));

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
